// File: rtl/play_rate_sequencer_if.sv
// SRAM read-port bundle between the playback sequencer (master) and the SRAM controller (slave).
interface play_rate_sequencer_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) ();
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (output rd_req, output rd_addr, input rd_data, input rd_valid);
    modport slave  (input rd_req, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/play_rate_sequencer.sv
// Variable-rate playback scheduler: per DAC sample request, fetch a new SRAM word or re-emit the held one.
// Optional build macro LINEAR_INTERP_EN: linear interpolation between words at slow speeds.
module play_rate_sequencer #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             top_state,
    input  logic [3:0]             play_speed,
    input  logic [ADDR_W-1:0]      end_addr,
    input  logic                   sample_req,
    play_rate_sequencer_if.master  sram,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    output logic                   done,
    output logic                   overrun
);
    localparam int unsigned AW1 = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EMIT
`ifdef LINEAR_INTERP_EN
        , S_FETCH2, S_WAIT2
`endif
    } state_t;

    function automatic logic [3:0] step_of(input logic [3:0] c);
        return (c >= 4'd9) ? 4'(c - 4'd7) : 4'd1;
    endfunction

    function automatic logic [3:0] hold_of(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd7) ? 4'(c + 4'd1) : 4'd1;
    endfunction

    state_t            state_q, state_d;
    logic [AW1-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic [2:0]        hold_cnt_q, hold_cnt_d;
    logic [3:0]        speed_q, speed_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              ended_q, ended_d;
    logic              overrun_q, overrun_d;
    logic              discard_q, discard_d;

    logic [2:0]        hold_eff_c;
    logic              past_end_c;
    logic              commit_c;
    logic [DATA_W-1:0] hold_val_c;

    assign hold_eff_c = (play_speed == speed_q) ? hold_cnt_q : 3'd0;
    assign past_end_c = addr_q > {1'b0, end_addr};

`ifdef LINEAR_INTERP_EN
    localparam int SMAX = (2 ** (DATA_W - 1)) - 1;
    localparam int SMIN = -(2 ** (DATA_W - 1));

    logic [DATA_W-1:0]   next_q, next_d;
    logic [3:0]          k_c;
    logic signed [31:0]  kr_c;
    logic signed [DATA_W:0] diff_c;
    logic signed [31:0]  sum_c;

    function automatic logic [12:0] recip(input logic [3:0] n);
        case (n)
            4'd2:    return 13'd2048;
            4'd3:    return 13'd1365;
            4'd4:    return 13'd1024;
            4'd5:    return 13'd819;
            4'd6:    return 13'd683;
            4'd7:    return 13'd585;
            4'd8:    return 13'd512;
            default: return 13'd4096;
        endcase
    endfunction

    function automatic logic is_slow(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd7);
    endfunction

    // Interpolated sample k of N: prev + ((next-prev)*k*round(4096/N)) >>> 12, saturated.
    always_comb begin
        k_c    = 4'(hold_of(speed_q) - {1'b0, hold_eff_c});
        kr_c   = $signed(32'(k_c) * 32'(recip(hold_of(speed_q))));
        diff_c = $signed({next_q[DATA_W-1], next_q}) - $signed({held_q[DATA_W-1], held_q});
        sum_c  = 32'($signed(held_q)) + ((32'(diff_c) * kr_c) >>> 12);
        if (sum_c > SMAX)      hold_val_c = DATA_W'(SMAX);
        else if (sum_c < SMIN) hold_val_c = DATA_W'(SMIN);
        else                   hold_val_c = sum_c[DATA_W-1:0];
    end
`else
    assign hold_val_c = held_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            held_q      <= '0;
            hold_cnt_q  <= '0;
            speed_q     <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ended_q     <= 1'b0;
            overrun_q   <= 1'b0;
            discard_q   <= 1'b0;
`ifdef LINEAR_INTERP_EN
            next_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            held_q      <= held_d;
            hold_cnt_q  <= hold_cnt_d;
            speed_q     <= speed_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            ended_q     <= ended_d;
            overrun_q   <= overrun_d;
            discard_q   <= discard_d;
`ifdef LINEAR_INTERP_EN
            next_q      <= next_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        held_d      = held_q;
        hold_cnt_d  = hold_cnt_q;
        speed_d     = speed_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        ended_d     = ended_q;
        overrun_d   = overrun_q;
        discard_d   = discard_q;
        commit_c    = 1'b0;
`ifdef LINEAR_INTERP_EN
        next_d      = next_q;
`endif
        // The first rd_valid after an abandoned read belongs to that read.
        if (sram.rd_valid && discard_q) discard_d = 1'b0;

        if (top_state != 3'b010) begin
            if (state_q != S_IDLE && state_q != S_EMIT) discard_d = discard_q | ~sram.rd_valid;
            state_d = S_IDLE;
            if (top_state == 3'b011) begin
                if (sample_req) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                end
            end else begin
                addr_d     = '0;
                hold_cnt_d = '0;
                held_d     = '0;
                ended_d    = 1'b0;
                overrun_d  = 1'b0;
`ifdef LINEAR_INTERP_EN
                next_d     = '0;
`endif
            end
        end else begin
            if (play_speed != speed_q) hold_cnt_d = '0;
            if (sample_req && state_q != S_IDLE) overrun_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (sample_req) begin
                        if (hold_eff_c != 3'd0) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_val_c;
                            hold_cnt_d  = 3'(hold_eff_c - 3'd1);
                        end else if (past_end_c) begin
                            out_valid_d = 1'b1;
                            out_data_d  = '0;
                            done_d      = ~ended_q;
                            ended_d     = 1'b1;
                        end else begin
                            state_d    = S_FETCH;
                            rd_req_d   = 1'b1;
                            rd_addr_d  = addr_q[ADDR_W-1:0];
                            speed_d    = play_speed;
                            hold_cnt_d = '0;
                        end
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (sram.rd_valid && !discard_q) begin
                        held_d = sram.rd_data;
`ifdef LINEAR_INTERP_EN
                        if (is_slow(speed_q) && (addr_q + AW1'(1)) <= {1'b0, end_addr}) begin
                            state_d   = S_FETCH2;
                            rd_req_d  = 1'b1;
                            rd_addr_d = ADDR_W'(addr_q + AW1'(1));
                        end else begin
                            next_d   = '0;
                            commit_c = 1'b1;
                        end
`else
                        commit_c = 1'b1;
`endif
                    end
                end
`ifdef LINEAR_INTERP_EN
                S_FETCH2: state_d = S_WAIT2;
                S_WAIT2: begin
                    if (sram.rd_valid && !discard_q) begin
                        next_d   = sram.rd_data;
                        commit_c = 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase

            // Fetch complete: emit the new word and advance by the latched speed.
            if (commit_c) begin
                state_d     = S_EMIT;
                out_valid_d = 1'b1;
                out_data_d  = held_d;
                addr_d      = addr_q + AW1'(step_of(speed_q));
                hold_cnt_d  = 3'(hold_of(speed_q) - 4'd1);
            end
        end
    end

    assign sram.rd_req  = rd_req_q;
    assign sram.rd_addr = rd_addr_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_play_rate_sequencer.sv
// Directed bench for play_rate_sequencer with a behavioural SRAM of programmable read latency.
module tb_play_rate_sequencer;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        top_state;
    logic [3:0]        play_speed;
    logic [ADDR_W-1:0] end_addr;
    logic              sample_req;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              done;
    logic              overrun;

    play_rate_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

    play_rate_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .top_state (top_state),
        .play_speed(play_speed),
        .end_addr  (end_addr),
        .sample_req(sample_req),
        .sram      (sif.master),
        .out_data  (out_data),
        .out_valid (out_valid),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // SRAM model: one outstanding read, data returned lat cycles after rd_req is seen.
    logic [DATA_W-1:0] mem [0:63];
    int                lat = 1;
    int                pend_cnt = 0;
    logic [5:0]        pend_addr = '0;

    always @(posedge clk) begin
        sif.rd_valid <= 1'b0;
        if (pend_cnt == 1) begin
            sif.rd_valid <= 1'b1;
            sif.rd_data  <= mem[pend_addr];
        end
        if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
        if (sif.rd_req) begin
            pend_cnt  <= lat;
            pend_addr <= sif.rd_addr[5:0];
        end
    end

    int                rd_cnt = 0;
    int                ov_cnt = 0;
    int                done_cnt = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;

    always @(negedge clk) begin
        if (sif.rd_req) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= sif.rd_addr;
        end
        if (out_valid) ov_cnt   <= ov_cnt + 1;
        if (done)      done_cnt <= done_cnt + 1;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_req(input string tag, output logic [DATA_W-1:0] d, output logic dn);
        bit got;
        got = 1'b0;
        d   = '0;
        dn  = 1'b0;
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1;
                d   = out_data;
                dn  = done;
            end else begin
                @(negedge clk);
            end
        end
        check_eq({tag, "_resp"}, 32'(got), 32'd1);
    endtask

    task automatic req_chk(input string tag, input logic [DATA_W-1:0] exp_d, input logic exp_dn);
        logic [DATA_W-1:0] d;
        logic              dn;
        do_req(tag, d, dn);
        check_eq({tag, "_data"}, 32'(d), 32'(exp_d));
        check_eq({tag, "_done"}, 32'(dn), 32'(exp_dn));
    endtask

    task automatic restart(input logic [3:0] spd, input logic [ADDR_W-1:0] ea);
        top_state = 3'b000;
        repeat (2) @(negedge clk);
        play_speed = spd;
        end_addr   = ea;
        top_state  = 3'b010;
        @(negedge clk);
    endtask

    int base;
`ifdef LINEAR_INTERP_EN
    logic [DATA_W-1:0] exp_slow [4] = '{16'd0, 16'd100, 16'd200, 16'd300};
`else
    logic [DATA_W-1:0] exp_slow [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
`endif

    initial begin
        rst        = 1'b0;
        top_state  = 3'b000;
        play_speed = 4'd0;
        end_addr   = '0;
        sample_req = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(i);
        repeat (3) @(negedge clk);

        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_done",      32'(done),      32'd0);
        check_eq("rst_overrun",   32'(overrun),   32'd0);
        check_eq("rst_rd_req",    32'(sif.rd_req), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // x1 playback
        restart(4'b0000, ADDR_W'(100));
        base = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            req_chk($sformatf("x1_%0d", i), DATA_W'(i), 1'b0);
            check_eq($sformatf("x1_addr_%0d", i), 32'(last_rd_addr), 32'(i));
        end
        settle();
        check_eq("x1_rd_cnt", 32'(rd_cnt - base), 32'd4);

        // x3 playback up to and past end_addr
        restart(4'b1010, ADDR_W'(10));
        base = done_cnt;
        for (int i = 0; i < 4; i++) begin
            req_chk($sformatf("x3_%0d", i), DATA_W'(3 * i), 1'b0);
            check_eq($sformatf("x3_addr_%0d", i), 32'(last_rd_addr), 32'(3 * i));
        end
        req_chk("x3_end", '0, 1'b1);
        req_chk("x3_after_end", '0, 1'b0);
        settle();
        check_eq("x3_done_cnt", 32'(done_cnt - base), 32'd1);

        // x1/4 playback
        restart(4'b0011, ADDR_W'(100));
        base = rd_cnt;
`ifdef LINEAR_INTERP_EN
        mem[1] = 16'd400;
`endif
        foreach (exp_slow[i]) req_chk($sformatf("slow_%0d", i), exp_slow[i], 1'b0);
        settle();
        check_eq("slow_rd_cnt", 32'(rd_cnt - base), 32'd2);
        mem[1] = 16'd1;

        // pause freezes position at addr 5
        restart(4'b0000, ADDR_W'(100));
        for (int i = 0; i < 5; i++) req_chk($sformatf("pre_pause_%0d", i), DATA_W'(i), 1'b0);
        top_state = 3'b011;
        settle();
        base = rd_cnt;
        req_chk("pause_0", '0, 1'b0);
        req_chk("pause_1", '0, 1'b0);
        settle();
        check_eq("pause_rd_cnt", 32'(rd_cnt - base), 32'd0);
        top_state = 3'b010;
        @(negedge clk);
        req_chk("resume", DATA_W'(5), 1'b0);
        check_eq("resume_addr", 32'(last_rd_addr), 32'd5);

        // second request while a read is in flight
        check_eq("ovr_before", 32'(overrun), 32'd0);
        lat = 4;
        settle();
        base = ov_cnt;
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("ovr_set", 32'(overrun), 32'd1);
        settle();
        check_eq("ovr_single_out", 32'(ov_cnt - base), 32'd1);
        top_state = 3'b000;
        repeat (2) @(negedge clk);
        check_eq("ovr_cleared", 32'(overrun), 32'd0);
        lat = 1;
        restart(4'b0000, ADDR_W'(100));
        req_chk("ovr_restart", '0, 1'b0);
        check_eq("ovr_restart_addr", 32'(last_rd_addr), 32'd0);

        // stop while waiting on SRAM: late data must be dropped
        restart(4'b0000, ADDR_W'(100));
        lat = 6;
        settle();
        base = ov_cnt;
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        repeat (2) @(negedge clk);
        top_state = 3'b000;
        repeat (12) @(negedge clk);
        settle();
        check_eq("stop_wait_no_out", 32'(ov_cnt - base), 32'd0);
        lat = 1;
        top_state = 3'b010;
        @(negedge clk);
        req_chk("stop_wait_restart", '0, 1'b0);
        check_eq("stop_wait_addr", 32'(last_rd_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
